// File: rtl/sw_array_ctrl.sv
// Control sequencer for the linear systolic Smith-Waterman PE array: shifts the query into
// the PE chain, streams the target into PE0, drains the wavefront and captures the best score.
module sw_array_ctrl #(
  parameter int PE_NUM     = 64,
  parameter int PE_IDX_BIT = 7,
  parameter int LEN_BIT    = 16,
  parameter int SCORE_BIT  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PE_IDX_BIT-1:0] s_len,
  input  logic [LEN_BIT-1:0]    t_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SCORE_BIT-1:0]  score,
  output logic [PE_IDX_BIT-1:0] s_addr,
  input  logic [1:0]            s_data,
  output logic                  pe_s_shift,
  output logic [1:0]            pe_s_data,
  input  logic                  t_valid,
  input  logic [1:0]            t_data,
  output logic                  t_ready,
  output logic                  pe_enable,
  output logic                  pe_lock,
  output logic                  pe_newline,
  output logic [1:0]            pe_t,
  output logic                  pe_bubble,
  input  logic [SCORE_BIT-1:0]  max_in
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  localparam logic [PE_IDX_BIT-1:0] PE_NUM_N = PE_IDX_BIT'(PE_NUM);
  localparam logic [PE_IDX_BIT-1:0] LAST_IDX = PE_IDX_BIT'(PE_NUM - 1);
  localparam logic [PE_IDX_BIT:0]   PE_NUM_W = (PE_IDX_BIT + 1)'(PE_NUM);

  state_t                  state, stateNxt;
  logic [PE_IDX_BIT-1:0]   loadCnt, loadCntNxt;
  logic [PE_IDX_BIT-1:0]   drainCnt, drainCntNxt;
  logic [LEN_BIT-1:0]      tCnt, tCntNxt;
  logic [PE_IDX_BIT-1:0]   sLenReg, sLenNxt;
  logic [LEN_BIT-1:0]      tLenReg, tLenNxt;
  logic [PE_IDX_BIT:0]     loadSum;
  logic                    startOk;

  logic                    busyNxt, doneNxt, errNxt;
  logic [SCORE_BIT-1:0]    scoreNxt;
  logic [PE_IDX_BIT-1:0]   sAddrNxt;
  logic                    shiftNxt;
  logic [1:0]              shiftDataNxt;
  logic                    tReadyNxt, enableNxt, lockNxt, newlineNxt, bubbleNxt;
  logic [1:0]              peTNxt;

  // loadCnt + s_len <= PE_NUM marks a pad slot; the query fills the far end of the chain.
  assign loadSum = {1'b0, loadCnt} + {1'b0, sLenReg};
  assign startOk = (s_len != '0) && (s_len <= PE_NUM_N) && (t_len != '0);

  always_comb begin
    stateNxt     = state;
    loadCntNxt   = loadCnt;
    drainCntNxt  = drainCnt;
    tCntNxt      = tCnt;
    sLenNxt      = sLenReg;
    tLenNxt      = tLenReg;
    busyNxt      = busy;
    doneNxt      = 1'b0;
    errNxt       = 1'b0;
    scoreNxt     = score;
    sAddrNxt     = s_addr;
    shiftNxt     = 1'b0;
    shiftDataNxt = 2'd0;
    tReadyNxt    = 1'b0;
    enableNxt    = 1'b0;
    lockNxt      = 1'b0;
    newlineNxt   = 1'b0;
    peTNxt       = pe_t;
    bubbleNxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (startOk) begin
            stateNxt   = LOAD;
            sLenNxt    = s_len;
            tLenNxt    = t_len;
            loadCntNxt = '0;
            tCntNxt    = '0;
            busyNxt    = 1'b1;
            scoreNxt   = '0;
          end else begin
            errNxt = 1'b1;
          end
        end
      end

      LOAD: begin
        // Count 0 only issues the first address; shift k carries the data read for address k.
        if (loadCnt != '0) begin
          shiftNxt     = 1'b1;
          shiftDataNxt = (loadSum <= PE_NUM_W) ? 2'd0 : s_data;
        end
        if (loadCnt == PE_NUM_N) begin
          stateNxt  = RUN;
          tReadyNxt = 1'b1;
        end else begin
          if (!(loadSum < PE_NUM_W))
            sAddrNxt = LAST_IDX - loadCnt;
          loadCntNxt = loadCnt + 1'b1;
        end
      end

      RUN: begin
        enableNxt = 1'b1;
        tReadyNxt = 1'b1;
        if (t_valid) begin
          peTNxt     = t_data;
          newlineNxt = (tCnt == '0);
          tCntNxt    = tCnt + 1'b1;
          if (tCnt == tLenReg - 1'b1) begin
            stateNxt    = DRAIN;
            tReadyNxt   = 1'b0;
            drainCntNxt = sLenReg - 1'b1;
          end
        end else begin
          lockNxt = 1'b1;
        end
      end

      DRAIN: begin
        enableNxt = 1'b1;
        bubbleNxt = 1'b1;
        peTNxt    = 2'd0;
        if (drainCnt == '0)
          stateNxt = DONE;
        else
          drainCntNxt = drainCnt - 1'b1;
      end

      DONE: begin
        doneNxt  = 1'b1;
        busyNxt  = 1'b0;
        scoreNxt = max_in;
        stateNxt = IDLE;
      end

      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      loadCnt    <= '0;
      drainCnt   <= '0;
      tCnt       <= '0;
      sLenReg    <= '0;
      tLenReg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      score      <= '0;
      s_addr     <= '0;
      pe_s_shift <= 1'b0;
      pe_s_data  <= 2'd0;
      t_ready    <= 1'b0;
      pe_enable  <= 1'b0;
      pe_lock    <= 1'b0;
      pe_newline <= 1'b0;
      pe_t       <= 2'd0;
      pe_bubble  <= 1'b0;
    end else begin
      state      <= stateNxt;
      loadCnt    <= loadCntNxt;
      drainCnt   <= drainCntNxt;
      tCnt       <= tCntNxt;
      sLenReg    <= sLenNxt;
      tLenReg    <= tLenNxt;
      busy       <= busyNxt;
      done       <= doneNxt;
      err        <= errNxt;
      score      <= scoreNxt;
      s_addr     <= sAddrNxt;
      pe_s_shift <= shiftNxt;
      pe_s_data  <= shiftDataNxt;
      t_ready    <= tReadyNxt;
      pe_enable  <= enableNxt;
      pe_lock    <= lockNxt;
      pe_newline <= newlineNxt;
      pe_t       <= peTNxt;
      pe_bubble  <= bubbleNxt;
    end
  end

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Scoreboard bench for sw_array_ctrl with a 4-PE array and a combinational query memory.
module tb_sw_array_ctrl;

  localparam int PE  = 4;
  localparam int PIB = 7;
  localparam int LB  = 16;
  localparam int SB  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [PIB-1:0] s_len;
  logic [LB-1:0]  t_len;
  logic           busy, done, err;
  logic [SB-1:0]  score;
  logic [PIB-1:0] s_addr;
  logic [1:0]     s_data;
  logic           pe_s_shift;
  logic [1:0]     pe_s_data;
  logic           t_valid;
  logic [1:0]     t_data;
  logic           t_ready;
  logic           pe_enable, pe_lock, pe_newline, pe_bubble;
  logic [1:0]     pe_t;
  logic [SB-1:0]  max_in;

  logic [1:0]     qmem [0:7];
  logic [1:0]     expShift [$];
  logic [2:0]     expChar [$];
  logic [SB-1:0]  expScore [$];
  logic [SB-1:0]  lastMx;

  int checks = 0;
  int errors = 0;
  int shiftCnt = 0, charCnt = 0, nlCnt = 0, lockCnt = 0, bubbleCnt = 0, errCnt = 0;

  always #5 clk = ~clk;

  assign s_data = qmem[s_addr[2:0]];

  sw_array_ctrl #(.PE_NUM(PE), .PE_IDX_BIT(PIB), .LEN_BIT(LB), .SCORE_BIT(SB)) dut (
    .clk(clk), .rst(rst), .start(start), .s_len(s_len), .t_len(t_len),
    .busy(busy), .done(done), .err(err), .score(score),
    .s_addr(s_addr), .s_data(s_data), .pe_s_shift(pe_s_shift), .pe_s_data(pe_s_data),
    .t_valid(t_valid), .t_data(t_data), .t_ready(t_ready),
    .pe_enable(pe_enable), .pe_lock(pe_lock), .pe_newline(pe_newline),
    .pe_t(pe_t), .pe_bubble(pe_bubble), .max_in(max_in)
  );

  // Consumer side of the scoreboard: pops expectations as the DUT emits them.
  task automatic monitor();
    logic [1:0]    es;
    logic [2:0]    ec;
    logic [SB-1:0] esc;
    forever begin
      @(negedge clk);
      if (err) errCnt++;
      if (pe_s_shift) begin
        shiftCnt++;
        checks++;
        if (expShift.size() == 0) begin
          errors++; $display("FAIL shift_data: got %0d, no shift expected", pe_s_data);
        end else begin
          es = expShift.pop_front();
          if (pe_s_data !== es) begin
            errors++; $display("FAIL shift_data: got %0d, expected %0d", pe_s_data, es);
          end
        end
      end
      if (pe_enable && !pe_lock && !pe_bubble) begin
        charCnt++;
        if (pe_newline) nlCnt++;
        checks++;
        if (expChar.size() == 0) begin
          errors++; $display("FAIL target_char: got nl=%0b t=%0d, no char expected", pe_newline, pe_t);
        end else begin
          ec = expChar.pop_front();
          if ({pe_newline, pe_t} !== ec) begin
            errors++;
            $display("FAIL target_char: got nl=%0b t=%0d, expected nl=%0b t=%0d", pe_newline, pe_t, ec[2], ec[1:0]);
          end
        end
      end
      if (pe_enable && pe_lock) lockCnt++;
      if (pe_bubble) bubbleCnt++;
      if (pe_enable && (pe_lock || pe_bubble)) begin
        checks++;
        if (pe_newline !== 1'b0) begin
          errors++; $display("FAIL newline_quiet: got %0b during stall/bubble, expected 0", pe_newline);
        end
      end
      if (done) begin
        checks++;
        if (expScore.size() == 0) begin
          errors++; $display("FAIL score: done with score %0d, no done expected", score);
        end else begin
          esc = expScore.pop_front();
          if (score !== esc) begin
            errors++; $display("FAIL score: got %0d, expected %0d", score, esc);
          end
        end
      end
    end
  endtask

  // Producer side: runs one alignment, pushing expectations as stimulus is driven.
  task automatic drive_job(input int sl, input int tl, input int stallAt, input int stallLen,
                           input int injCyc, input bit abortOnBubble, output int lat);
    logic [1:0]    tgt [$];
    logic [SB-1:0] mx;
    int            sent, stallCnt, cyc;
    bit            tv;
    mx = SB'($urandom_range(1, 16'hfff0));
    lastMx = mx;
    for (int k = 0; k < PE; k++) qmem[k] = 2'($urandom_range(0, 3));
    for (int j = 0; j < PE; j++) expShift.push_back((j < PE - sl) ? 2'd0 : qmem[PE - 1 - j]);
    for (int k = 0; k < tl; k++) tgt.push_back(2'($urandom_range(0, 3)));
    expScore.push_back(mx);
    max_in = mx;
    s_len  = PIB'(sl);
    t_len  = LB'(tl);
    start  = 1'b1;
    sent = 0; stallCnt = 0; cyc = 0; lat = -1;
    while (cyc < 3000) begin
      if (cyc > 0 && done) begin lat = cyc; break; end
      if (abortOnBubble && pe_bubble) break;
      tv = (sent >= tl) || !(sent == stallAt && stallCnt < stallLen);
      t_valid = tv;
      t_data  = (sent < tl) ? tgt[sent] : 2'd3;
      if (t_ready && sent < tl) begin
        if (tv) begin
          expChar.push_back({(sent == 0), tgt[sent]});
          sent++;
        end else begin
          stallCnt++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; s_len = '0; t_len = '0;
      if (cyc == injCyc) begin
        start = 1'b1; s_len = PIB'(PE); t_len = LB'(1);
      end
    end
    t_valid = 1'b0;
    start   = 1'b0;
    if (lat < 0 && !abortOnBubble) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; s_len = '0; t_len = '0; t_valid = 1'b0; t_data = '0; max_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, score, s_addr, pe_s_shift, pe_s_data, t_ready, pe_enable,
         pe_lock, pe_newline, pe_t, pe_bubble} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%0b score=%0d en=%0b rdy=%0b, expected all 0",
                         busy, score, pe_enable, t_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, s0, c0, n0, b0, e0;
    s0 = shiftCnt; c0 = charCnt; n0 = nlCnt; b0 = bubbleCnt; e0 = errCnt;
    drive_job(3, 5, -1, 0, -1, 1'b0, lat);
    checks++; if (lat !== 15) begin errors++; $display("FAIL basic_latency: got %0d, expected 15", lat); end
    @(negedge clk);
    checks++; if (shiftCnt - s0 !== 4) begin errors++; $display("FAIL basic_shifts: got %0d, expected 4", shiftCnt - s0); end
    checks++; if (charCnt - c0 !== 5) begin errors++; $display("FAIL basic_chars: got %0d, expected 5", charCnt - c0); end
    checks++; if (nlCnt - n0 !== 1) begin errors++; $display("FAIL basic_newline: got %0d, expected 1", nlCnt - n0); end
    checks++; if (bubbleCnt - b0 !== 3) begin errors++; $display("FAIL basic_bubbles: got %0d, expected 3", bubbleCnt - b0); end
    checks++; if (errCnt - e0 !== 0) begin errors++; $display("FAIL basic_err: got %0d, expected 0", errCnt - e0); end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00 || score !== lastMx) begin
      errors++; $display("FAIL basic_hold: got done=%0b busy=%0b score=%0d, expected 0 0 %0d", done, busy, score, lastMx);
    end
  endtask

  task automatic test_stall();
    int lat, l0, c0, n0;
    l0 = lockCnt; c0 = charCnt; n0 = nlCnt;
    drive_job(3, 5, 2, 2, -1, 1'b0, lat);
    checks++; if (lat !== 17) begin errors++; $display("FAIL stall_latency: got %0d, expected 17", lat); end
    @(negedge clk);
    checks++; if (lockCnt - l0 !== 2) begin errors++; $display("FAIL stall_locks: got %0d, expected 2", lockCnt - l0); end
    checks++; if (charCnt - c0 !== 5) begin errors++; $display("FAIL stall_chars: got %0d, expected 5", charCnt - c0); end
    checks++; if (nlCnt - n0 !== 1) begin errors++; $display("FAIL stall_newline: got %0d, expected 1", nlCnt - n0); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int sl [3] = '{0, 5, 3};
    int tl [3] = '{5, 5, 0};
    int e0;
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1; @(posedge clk); #1;
    e0 = errCnt;
    for (int i = 0; i < 3; i++) begin
      s_len = PIB'(sl[i]); t_len = LB'(tl[i]); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({err, busy} !== 2'b10) begin
        errors++; $display("FAIL illegal_err_%0d: got err=%0b busy=%0b, expected 1 0", i, err, busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({err, busy, pe_s_shift} !== 3'b000 || s_addr !== '0) begin
        errors++; $display("FAIL illegal_quiet_%0d: got err=%0b busy=%0b shift=%0b addr=%0d, expected all 0",
                           i, err, busy, pe_s_shift, s_addr);
      end
    end
    @(negedge clk);
    checks++; if (errCnt - e0 !== 3) begin errors++; $display("FAIL illegal_count: got %0d, expected 3", errCnt - e0); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_in_run();
    int lat, b0, c0, e0;
    b0 = bubbleCnt; c0 = charCnt; e0 = errCnt;
    drive_job(2, 6, -1, 0, 8, 1'b0, lat);
    checks++; if (lat !== 15) begin errors++; $display("FAIL inject_latency: got %0d, expected 15", lat); end
    @(negedge clk);
    checks++; if (bubbleCnt - b0 !== 2) begin errors++; $display("FAIL inject_bubbles: got %0d, expected 2", bubbleCnt - b0); end
    checks++; if (charCnt - c0 !== 6) begin errors++; $display("FAIL inject_chars: got %0d, expected 6", charCnt - c0); end
    checks++; if (errCnt - e0 !== 0) begin errors++; $display("FAIL inject_err: got %0d, expected 0", errCnt - e0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_drain();
    int lat;
    drive_job(3, 2, -1, 0, -1, 1'b1, lat);
    checks++; if (pe_bubble !== 1'b1) begin errors++; $display("FAIL rstdrain_reach: got bubble=%0b, expected 1", pe_bubble); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, err, score, s_addr, pe_s_shift, pe_s_data, t_ready, pe_enable,
         pe_lock, pe_newline, pe_t, pe_bubble} !== '0) begin
      errors++; $display("FAIL rstdrain_outputs: got busy=%0b score=%0d en=%0b bub=%0b, expected all 0",
                         busy, score, pe_enable, pe_bubble);
    end
    expScore.delete(); expShift.delete(); expChar.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    drive_job(3, 5, -1, 0, -1, 1'b0, lat);
    checks++; if (lat !== 15) begin errors++; $display("FAIL rstdrain_rerun: got %0d, expected 15", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_query();
    int lat, s0, n0, b0;
    s0 = shiftCnt; n0 = nlCnt; b0 = bubbleCnt;
    drive_job(4, 1, -1, 0, -1, 1'b0, lat);
    checks++; if (lat !== 12) begin errors++; $display("FAIL full_latency: got %0d, expected 12", lat); end
    @(negedge clk);
    checks++; if (shiftCnt - s0 !== 4) begin errors++; $display("FAIL full_shifts: got %0d, expected 4", shiftCnt - s0); end
    checks++; if (nlCnt - n0 !== 1) begin errors++; $display("FAIL full_newline: got %0d, expected 1", nlCnt - n0); end
    checks++; if (bubbleCnt - b0 !== 4) begin errors++; $display("FAIL full_bubbles: got %0d, expected 4", bubbleCnt - b0); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, sl, tl, sa, sn, expLat, l0;
    for (int i = 0; i < 4; i++) begin
      sl = $urandom_range(1, PE);
      tl = $urandom_range(1, 12);
      sa = $urandom_range(0, tl - 1);
      sn = $urandom_range(0, 3);
      expLat = 1 + (PE + 1) + tl + sn + sl + 1;
      l0 = lockCnt;
      drive_job(sl, tl, sa, sn, -1, 1'b0, lat);
      checks++;
      if (lat !== expLat) begin
        errors++; $display("FAIL b2b_latency_%0d: got %0d, expected %0d (s=%0d t=%0d stall=%0d)", i, lat, expLat, sl, tl, sn);
      end
      checks++;
      if (lockCnt - l0 !== sn) begin
        errors++; $display("FAIL b2b_locks_%0d: got %0d, expected %0d", i, lockCnt - l0, sn);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (expShift.size() + expChar.size() + expScore.size() != 0) begin
      errors++; $display("FAIL scoreboard_drained: got %0d/%0d/%0d pending, expected 0/0/0",
                         expShift.size(), expChar.size(), expScore.size());
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) qmem[k] = 2'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_illegal();
    test_start_in_run();
    test_reset_drain();
    test_full_query();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
